// File: rtl/axil_pkg.sv
// Shared types and constants for the AXI4-Lite command manager.
// No ports. Provides response codes, the FSM state encoding, the default
// AxPROT value, and the command and response record types.
package axil_pkg;

    localparam logic [1:0] RespOkay    = 2'b00;
    localparam logic [1:0] RespSlvErr  = 2'b10;
    localparam logic [1:0] RespDecErr  = 2'b11;
    localparam logic [2:0] ProtDefault = 3'b000;

    typedef enum logic [2:0] {
        StateResetExit,
        StateIdle,
        StateWaddr,
        StateWaitB,
        StateRaddr,
        StateWaitR,
        StateResp
    } state_e;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } cmd_t;

    typedef struct packed {
        logic        write;
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic        timeout;
    } rsp_t;

    // A subordinate reported an error (SLVERR or DECERR).
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == RespSlvErr) || (resp == RespDecErr);
    endfunction

endpackage

// File: rtl/axil_cmd_manager_if.sv
// AXI4-Lite bus bundle, 32-bit address and data.
// Modports:
//   master - the manager side: drives AW/W/AR payload and valids, B/R readies.
//   slave  - the subordinate side: the mirror image.
interface axil_cmd_manager_if;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid,    input wready,
        input  bresp, bvalid,           output bready,
        output araddr, arprot, arvalid, input arready,
        input  rdata, rresp, rvalid,    output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid,    output wready,
        output bresp, bvalid,           input bready,
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid,    input rready
    );
endinterface

// File: rtl/axil_cmd_manager_timeout_counter.sv
// Response-wait watchdog.
// Ports:
//   clk, resetn - clock, asynchronous active-low reset
//   clear       - restart the count from zero (has priority)
//   enable      - count this cycle
//   limit       - number of enabled cycles before expiry; 0 disables
//   expired     - high during the limit-th enabled cycle since the last clear
module timeout_counter #(
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] limit,
    output logic             expired
);

    logic [WIDTH-1:0] count_q;

    // Expiry is flagged in the cycle that would bring the count to limit,
    // so a limit of N yields exactly N waiting cycles.
    assign expired = enable && (limit != '0) && (count_q == limit - WIDTH'(1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && !expired) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

endmodule

// File: rtl/axil_cmd_manager.sv
// AXI4-Lite manager: turns a valid/ready command stream into single
// AXI4-Lite reads or writes, one outstanding, one response per command.
// Ports:
//   aclk, aresetn      - clock, asynchronous active-low reset
//   s_cmd_*            - command in (write, addr, wdata, wstrb)
//   m_rsp_*            - response out (write echo, rdata, resp, timeout)
//   m_axi_lite         - AXI4-Lite manager channels
//   busy               - FSM is anywhere but IDLE
//   stray_count        - saturating count of B/R beats absorbed in IDLE
module axil_cmd_manager
    import axil_pkg::*;
#(
    parameter int TIMEOUT_CYCLES  = 1024,
    parameter int STRAY_CNT_WIDTH = 8
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic                       s_cmd_valid,
    output logic                       s_cmd_ready,
    input  logic                       s_cmd_write,
    input  logic [31:0]                s_cmd_addr,
    input  logic [31:0]                s_cmd_wdata,
    input  logic [3:0]                 s_cmd_wstrb,
    output logic                       m_rsp_valid,
    input  logic                       m_rsp_ready,
    output logic                       m_rsp_write,
    output logic [31:0]                m_rsp_rdata,
    output logic [1:0]                 m_rsp_resp,
    output logic                       m_rsp_timeout,
    axil_cmd_manager_if.master         m_axi_lite,
    output logic                       busy,
    output logic [STRAY_CNT_WIDTH-1:0] stray_count
);

    localparam int TO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

    state_e state_q, state_d;
    cmd_t   cmd_q;
    rsp_t   rsp_q, rsp_d;
    logic   aw_done_q, w_done_q;
    logic   aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic   in_idle, in_wait;
    logic   to_expired;
    logic [STRAY_CNT_WIDTH-1:0] stray_q;
    logic [STRAY_CNT_WIDTH:0]   stray_sum;

    assign in_idle = (state_q == StateIdle);
    assign in_wait = (state_q == StateWaitB) || (state_q == StateWaitR);

    // Handshake strobes and bus outputs, all decoded from registered state.
    assign s_cmd_ready           = in_idle;
    assign m_axi_lite.awvalid    = (state_q == StateWaddr) && !aw_done_q;
    assign m_axi_lite.wvalid     = (state_q == StateWaddr) && !w_done_q;
    assign m_axi_lite.arvalid    = (state_q == StateRaddr);
    assign m_axi_lite.bready     = in_idle || (state_q == StateWaitB);
    assign m_axi_lite.rready     = in_idle || (state_q == StateWaitR);
    assign m_axi_lite.awaddr     = cmd_q.addr;
    assign m_axi_lite.araddr     = cmd_q.addr;
    assign m_axi_lite.wdata      = cmd_q.wdata;
    assign m_axi_lite.wstrb      = cmd_q.wstrb;
    assign m_axi_lite.awprot     = ProtDefault;
    assign m_axi_lite.arprot     = ProtDefault;

    assign aw_hs = m_axi_lite.awvalid && m_axi_lite.awready;
    assign w_hs  = m_axi_lite.wvalid  && m_axi_lite.wready;
    assign ar_hs = m_axi_lite.arvalid && m_axi_lite.arready;
    assign b_hs  = m_axi_lite.bvalid  && m_axi_lite.bready;
    assign r_hs  = m_axi_lite.rvalid  && m_axi_lite.rready;

    assign m_rsp_valid   = (state_q == StateResp);
    assign m_rsp_write   = rsp_q.write;
    assign m_rsp_rdata   = rsp_q.rdata;
    assign m_rsp_resp    = rsp_q.resp;
    assign m_rsp_timeout = rsp_q.timeout;
    assign busy          = !in_idle;
    assign stray_count   = stray_q;

    // Counter is held clear outside the wait states, so it starts at zero
    // on every entry to WAIT_B/WAIT_R.
    timeout_counter #(.WIDTH(TO_W)) u_timeout (
        .clk     (aclk),
        .resetn  (aresetn),
        .clear   (!in_wait),
        .enable  (in_wait),
        .limit   (TO_LIMIT),
        .expired (to_expired)
    );

    always_comb begin
        state_d = state_q;
        rsp_d   = rsp_q;
        unique case (state_q)
            StateResetExit: state_d = StateIdle;
            StateIdle: begin
                if (s_cmd_valid) state_d = s_cmd_write ? StateWaddr : StateRaddr;
            end
            StateWaddr: begin
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = StateWaitB;
            end
            StateWaitB: begin
                // A beat in the expiry cycle takes precedence over the timeout.
                if (b_hs) begin
                    rsp_d   = '{write: cmd_q.write, rdata: '0, resp: m_axi_lite.bresp, timeout: 1'b0};
                    state_d = StateResp;
                end else if (to_expired) begin
                    rsp_d   = '{write: cmd_q.write, rdata: '0, resp: RespSlvErr, timeout: 1'b1};
                    state_d = StateResp;
                end
            end
            StateRaddr: begin
                if (ar_hs) state_d = StateWaitR;
            end
            StateWaitR: begin
                if (r_hs) begin
                    rsp_d   = '{write: cmd_q.write, rdata: m_axi_lite.rdata,
                                resp: m_axi_lite.rresp, timeout: 1'b0};
                    state_d = StateResp;
                end else if (to_expired) begin
                    rsp_d   = '{write: cmd_q.write, rdata: '0, resp: RespSlvErr, timeout: 1'b1};
                    state_d = StateResp;
                end
            end
            StateResp: begin
                if (m_rsp_ready) state_d = StateIdle;
            end
            default: state_d = StateIdle;
        endcase
    end

    // Beats absorbed in IDLE; B and R can both land in one cycle.
    always_comb begin
        stray_sum = {1'b0, stray_q}
                  + {{STRAY_CNT_WIDTH{1'b0}}, in_idle && b_hs}
                  + {{STRAY_CNT_WIDTH{1'b0}}, in_idle && r_hs};
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= StateResetExit;
            cmd_q     <= '0;
            rsp_q     <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            stray_q   <= '0;
        end else begin
            state_q <= state_d;
            rsp_q   <= rsp_d;
            if (in_idle && s_cmd_valid) begin
                cmd_q <= '{write: s_cmd_write, addr: s_cmd_addr,
                           wdata: s_cmd_wdata, wstrb: s_cmd_wstrb};
            end
            // Per-channel done flags drop each valid independently.
            if (state_q != StateWaddr) begin
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
            end else begin
                if (aw_hs) aw_done_q <= 1'b1;
                if (w_hs)  w_done_q  <= 1'b1;
            end
            stray_q <= stray_sum[STRAY_CNT_WIDTH] ? '1 : stray_sum[STRAY_CNT_WIDTH-1:0];
        end
    end

endmodule
